// File: rtl/fmul_norm_round_if.sv
// Handshake/data bundle between the array multiplier, the normalise-and-round
// stage and the FPU writeback mux.
interface fmul_norm_round_if;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_prod;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_unf;
   logic        out_inexact;

   modport master (
      output in_valid, in_prod, in_sign, in_exp, in_zero, in_inf, in_nan, out_ready,
      input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
   );

   modport slave (
      input  in_valid, in_prod, in_sign, in_exp, in_zero, in_inf, in_nan, out_ready,
      output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
   );
endinterface

// File: rtl/fmul_norm_round.sv
// FP32 multiplier back end: stage 1 normalises the 48-bit significand product,
// stage 2 rounds to nearest-even, selects specials/overflow/flush and packs.
module fmul_norm_round (
   input  logic             clk,
   input  logic             rst_n,
   fmul_norm_round_if.slave bus
);
   logic              s1_valid_reg;
   logic [22:0]       s1_mant_reg;
   logic              s1_g_reg;
   logic              s1_s_reg;
   logic signed [9:0] s1_exp_reg;
   logic              s1_sign_reg;
   logic              s1_zero_reg;
   logic              s1_inf_reg;
   logic              s1_nan_reg;

   logic              s2_valid_reg;
   logic [31:0]       s2_result_reg;
   logic              s2_ovf_reg;
   logic              s2_unf_reg;
   logic              s2_inexact_reg;

   logic              s2_load;
   logic              s1_load;

   // Each stage refills whenever its contents move on, so there are no bubbles.
   assign s2_load      = !s2_valid_reg || bus.out_ready;
   assign s1_load      = !s1_valid_reg || s2_load;
   assign bus.in_ready = s1_load;

   logic              norm_hi;
   logic [22:0]       norm_mant;
   logic              norm_g;
   logic              norm_s;
   logic signed [9:0] norm_exp;

   assign norm_hi   = bus.in_prod[47];
   assign norm_mant = norm_hi ? bus.in_prod[46:24] : bus.in_prod[45:23];
   assign norm_g    = norm_hi ? bus.in_prod[23] : bus.in_prod[22];
   assign norm_s    = norm_hi ? (|bus.in_prod[22:0]) : (|bus.in_prod[21:0]);
   assign norm_exp  = $signed(bus.in_exp) + (norm_hi ? 10'sd1 : 10'sd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_mant_reg  <= '0;
         s1_g_reg     <= 1'b0;
         s1_s_reg     <= 1'b0;
         s1_exp_reg   <= '0;
         s1_sign_reg  <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_inf_reg   <= 1'b0;
         s1_nan_reg   <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mant_reg <= norm_mant;
            s1_g_reg    <= norm_g;
            s1_s_reg    <= norm_s;
            s1_exp_reg  <= norm_exp;
            s1_sign_reg <= bus.in_sign;
            s1_zero_reg <= bus.in_zero;
            s1_inf_reg  <= bus.in_inf;
            s1_nan_reg  <= bus.in_nan;
         end
      end
   end

   logic              round_up;
   logic [23:0]       round_sum;
   logic [22:0]       round_mant;
   logic signed [9:0] round_exp;

   // A carry out of the 23-bit fraction means 10.000..: fraction wraps to 0, exponent bumps.
   assign round_up   = s1_g_reg & (s1_s_reg | s1_mant_reg[0]);
   assign round_sum  = {1'b0, s1_mant_reg} + {23'd0, round_up};
   assign round_mant = round_sum[23] ? 23'd0 : round_sum[22:0];
   assign round_exp  = s1_exp_reg + (round_sum[23] ? 10'sd1 : 10'sd0);

   logic [31:0] result_next;
   logic        ovf_next;
   logic        unf_next;
   logic        inexact_next;

   always_comb begin
      result_next  = 32'd0;
      ovf_next     = 1'b0;
      unf_next     = 1'b0;
      inexact_next = 1'b0;
      if (s1_nan_reg) begin
         result_next = 32'h7FC0_0000;
      end else if (s1_inf_reg) begin
         result_next = {s1_sign_reg, 8'hFF, 23'd0};
      end else if (s1_zero_reg) begin
         result_next = {s1_sign_reg, 31'd0};
      end else if (round_exp >= 10'sd255) begin
         result_next  = {s1_sign_reg, 8'hFF, 23'd0};
         ovf_next     = 1'b1;
         inexact_next = 1'b1;
      end else if (round_exp <= 10'sd0) begin
         result_next  = {s1_sign_reg, 31'd0};
         unf_next     = 1'b1;
         inexact_next = 1'b1;
      end else begin
         result_next  = {s1_sign_reg, round_exp[7:0], round_mant};
         inexact_next = s1_g_reg | s1_s_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg   <= 1'b0;
         s2_result_reg  <= '0;
         s2_ovf_reg     <= 1'b0;
         s2_unf_reg     <= 1'b0;
         s2_inexact_reg <= 1'b0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_result_reg  <= result_next;
            s2_ovf_reg     <= ovf_next;
            s2_unf_reg     <= unf_next;
            s2_inexact_reg <= inexact_next;
         end
      end
   end

   assign bus.out_valid   = s2_valid_reg;
   assign bus.out_result  = s2_result_reg;
   assign bus.out_ovf     = s2_ovf_reg;
   assign bus.out_unf     = s2_unf_reg;
   assign bus.out_inexact = s2_inexact_reg;
endmodule

// File: tb/tb_fmul_norm_round.sv
// Bench for fmul_norm_round: directed corner cases plus a randomized sweep
// scored against an arithmetic reference model through a FIFO scoreboard.
module tb_fmul_norm_round;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fmul_norm_round_if bus();

   fmul_norm_round dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   logic [34:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference: scale the product to a 24-bit significand, round the discarded
   // remainder against exactly one half, then classify the final exponent.
   function automatic logic [34:0] ref_model(input logic [47:0] p, input logic sg, input int e,
                                             input logic z, input logic i, input logic n);
      logic [63:0] pw, q, rem, half;
      int          sh, ee;
      logic        inx;
      if (n) return {3'b000, 32'h7FC0_0000};
      if (i) return {3'b000, sg, 8'hFF, 23'd0};
      if (z) return {3'b000, sg, 31'd0};
      pw   = {16'd0, p};
      sh   = p[47] ? 24 : 23;
      ee   = p[47] ? e + 1 : e;
      q    = pw >> sh;
      rem  = pw - (q << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q >= (64'd1 << 24)) begin
         q  = q >> 1;
         ee = ee + 1;
      end
      if (ee >= 255) return {3'b101, sg, 8'hFF, 23'd0};
      if (ee <= 0)   return {3'b011, sg, 31'd0};
      return {2'b00, inx, sg, ee[7:0], q[22:0]};
   endfunction

   // Scoreboard: record every accepted item, match every delivered one in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_model(bus.in_prod, bus.in_sign, int'($signed(bus.in_exp)),
                                      bus.in_zero, bus.in_inf, bus.in_nan));
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               logic [34:0] e;
               e = exp_q.pop_front();
               check("mon_result", {32'd0, bus.out_result}, {32'd0, e[31:0]});
               check("mon_flags", {61'd0, bus.out_ovf, bus.out_unf, bus.out_inexact},
                     {61'd0, e[34:32]});
            end
         end
      end
   end

   task automatic drive_in(input logic [47:0] p, input logic sg, input int e,
                           input logic z, input logic i, input logic n);
      bus.in_prod = p;
      bus.in_sign = sg;
      bus.in_exp  = 10'(e);
      bus.in_zero = z;
      bus.in_inf  = i;
      bus.in_nan  = n;
   endtask

   task automatic directed(input string tag, input logic [47:0] p, input logic sg, input int e,
                           input logic z, input logic i, input logic n,
                           input logic [31:0] want_res, input logic [2:0] want_fl);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive_in(p, sg, e, z, i, n);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({tag, "_lat1_valid"}, {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk); #1;
      check({tag, "_lat2_valid"}, {63'd0, bus.out_valid}, 64'd1);
      check({tag, "_result"}, {32'd0, bus.out_result}, {32'd0, want_res});
      check({tag, "_flags"}, {61'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, {61'd0, want_fl});
      $display("[TB] txn %s result=%h ovf=%b unf=%b inexact=%b", tag, bus.out_result,
               bus.out_ovf, bus.out_unf, bus.out_inexact);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive_in(48'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      #12;
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_result", {32'd0, bus.out_result}, 64'd0);
      check("rst_flags", {61'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      directed("one_x_one",   48'h4000_0000_0000, 1'b0, 127, 0, 0, 0, 32'h3F80_0000, 3'b000);
      directed("1p5_x_1p5",   48'h9000_0000_0000, 1'b0, 127, 0, 0, 0, 32'h4010_0000, 3'b000);
      directed("round_up",    48'h4000_00C0_0000, 1'b0, 127, 0, 0, 0, 32'h3F80_0002, 3'b001);
      directed("tie_even",    48'h4000_0040_0000, 1'b0, 127, 0, 0, 0, 32'h3F80_0000, 3'b001);
      directed("mant_carry",  48'h7FFF_FFC0_0000, 1'b0, 127, 0, 0, 0, 32'h4000_0000, 3'b001);
      directed("overflow",    48'h8000_0000_0000, 1'b1, 254, 0, 0, 0, 32'hFF80_0000, 3'b101);
      directed("underflow",   48'h4000_0000_0000, 1'b0, 0,   0, 0, 0, 32'h0000_0000, 3'b011);
      directed("max_exp",     48'h4000_0000_0000, 1'b0, 254, 0, 0, 0, 32'h7F00_0000, 3'b000);
      directed("min_exp",     48'h4000_0000_0000, 1'b1, 1,   0, 0, 0, 32'h8080_0000, 3'b000);
      directed("exp_255",     48'h4000_0000_0000, 1'b0, 255, 0, 0, 0, 32'h7F80_0000, 3'b101);
      directed("nan",         48'h8123_4567_89AB, 1'b1, 300, 0, 0, 1, 32'h7FC0_0000, 3'b000);
      directed("inf_neg",     48'h4000_00C0_0000, 1'b1, -200, 0, 1, 0, 32'hFF80_0000, 3'b000);
      directed("zero_neg",    48'h7FFF_FFC0_0000, 1'b1, 381, 1, 0, 0, 32'h8000_0000, 3'b000);

      // Backpressure: two items fill the pipe, the third waits for release.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_in(48'h4000_0000_0000, 1'b0, 127, 0, 0, 0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_accept_a", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;
      drive_in(48'h9000_0000_0000, 1'b0, 127, 0, 0, 0);
      @(negedge clk);
      check("bp_accept_b", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;
      drive_in(48'h4000_00C0_0000, 1'b0, 127, 0, 0, 0);
      @(negedge clk);
      check("bp_full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_hold_a0", {32'd0, bus.out_result}, 64'h3F80_0000);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
         check("bp_stall_valid", {63'd0, bus.out_valid}, 64'd1);
         check("bp_hold_a", {32'd0, bus.out_result}, 64'h3F80_0000);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("bp_out_a", {32'd0, bus.out_result}, 64'h3F80_0000);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp_out_b_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_out_b", {32'd0, bus.out_result}, 64'h4010_0000);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_c_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_out_c", {32'd0, bus.out_result}, 64'h3F80_0002);
      @(posedge clk);
      @(negedge clk);
      check("bp_empty", {63'd0, bus.out_valid}, 64'd0);
      $display("[TB] txn backpressure three items drained");

      // Reset with both stages full: everything in flight is discarded.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_in(48'h9000_0000_0000, 1'b1, 127, 0, 0, 0);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      drive_in(48'h4000_0000_0000, 1'b1, 130, 0, 0, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_full_valid", {63'd0, bus.out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("mid_rst_result", {32'd0, bus.out_result}, 64'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_idle", {63'd0, bus.out_valid}, 64'd0);
      $display("[TB] txn reset mid-stream flushed");
      directed("post_rst", 48'h4000_0000_0000, 1'b0, 128, 0, 0, 0, 32'h4000_0000, 3'b000);

      // Randomized sweep with random backpressure, scored by the monitor.
      begin
         int cyc;
         cyc   = 0;
         n_acc = 0;
         while (n_acc < 10000 && cyc < 60000) begin
            longint unsigned a, b;
            int e, sel, k;
            logic [47:0] p;
            @(posedge clk); #1;
            cyc++;
            a = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            b = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            if ($urandom_range(0, 3) == 0) begin
               k = $urandom_range(1, 23);
               b = b & ~((64'd1 << k) - 64'd1);
            end
            p = 48'(a * b);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      e = int'($urandom_range(100, 160));
            else if (sel == 6) e = int'($urandom_range(250, 258));
            else if (sel == 7) e = int'($urandom_range(0, 4)) - 2;
            else               e = int'($urandom_range(0, 635)) - 254;
            sel = $urandom_range(0, 19);
            drive_in(p, 1'($urandom_range(0, 1)), e, sel == 0, sel == 1, sel == 2);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1;
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         repeat (6) @(posedge clk);
         #1;
         check("sweep_accepted", {63'd0, n_acc >= 10000}, 64'd1);
         check("sweep_drained", 64'(exp_q.size()), 64'd0);
         $display("[TB] txn random sweep %0d items in %0d cycles", n_acc, cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
